// File: rtl/led_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan path.
// The segment table is indexed by hex nibble and yields {g,f,e,d,c,b,a}.
package led_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   localparam int SEG_A  = 0;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to 7-segment decoder, one instance shared by all digits.
module hex7seg_dec
   import led_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/led_scan_ctrl.sv
// Multi-digit 7-segment scan controller: blank/show sequencing per digit,
// double-buffered host write that swaps into the display only at frame end.
module led_scan_ctrl
   import led_pkg::*;
#(
   parameter int N_DIGITS  = 4,
   parameter int DWELL     = 1000,
   parameter int BLANK_CYC = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ena,
   input  logic                  wr_vld,
   output logic                  wr_rdy,
   input  logic [4*N_DIGITS-1:0] wr_data,
   input  logic [N_DIGITS-1:0]   wr_dp,
   output logic [N_DIGITS-1:0]   dig_sel,
   output logic [7:0]            seg,
   output logic                  frame_done,
   output logic [1:0]            dbg_state
);

   // Handshake: a write is taken on any clk edge where wr_vld && wr_rdy;
   // wr_rdy depends only on the pending flag, never on wr_vld.

   localparam int CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
   localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IW      = $clog2(N_DIGITS);
   localparam logic [N_DIGITS-1:0] SEL_ONE = 1;

   state_t                r_state;
   logic [IW-1:0]         r_idx;
   logic [CW-1:0]         r_cnt;
   logic [4*N_DIGITS-1:0] r_front_data;
   logic [N_DIGITS-1:0]   r_front_dp;
   logic [4*N_DIGITS-1:0] r_back_data;
   logic [N_DIGITS-1:0]   r_back_dp;
   logic                  r_pending;

   logic                  w_dwell_end;
   logic                  w_blank_end;
   logic                  w_last_digit;
   logic [3:0]            w_nib;
   logic [6:0]            w_seg7;

   assign w_dwell_end  = (r_cnt == CW'(DWELL - 1));
   assign w_blank_end  = (r_cnt == CW'(BLANK_CYC - 1));
   assign w_last_digit = (r_idx == IW'(N_DIGITS - 1));
   assign w_nib        = r_front_data[r_idx*4 +: 4];

   hex7seg_dec u_dec (
      .i_nib (w_nib),
      .o_seg (w_seg7)
   );

   assign wr_rdy     = !r_pending;
   assign dbg_state  = r_state;
   // Qualified by ena so the pulse agrees with the swap, which a drop of ena suppresses.
   assign frame_done = (r_state == ST_SHOW) && w_dwell_end && w_last_digit && ena;
   assign dig_sel    = (r_state == ST_SHOW) ? (SEL_ONE << r_idx) : '0;

   always_comb begin
      seg = '0;
      if (r_state == ST_SHOW) begin
         seg[SEG_G:SEG_A] = w_seg7;
         seg[SEG_DP]      = r_front_dp[r_idx];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_front_data <= '0;
         r_front_dp   <= '0;
         r_back_data  <= '0;
         r_back_dp    <= '0;
         r_pending    <= 1'b0;
      end else begin
         if (wr_vld && !r_pending) begin
            r_back_data <= wr_data;
            r_back_dp   <= wr_dp;
            r_pending   <= 1'b1;
         end

         if (!ena) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_state <= ST_BLANK;
                  r_idx   <= '0;
                  r_cnt   <= '0;
               end
               ST_BLANK: begin
                  if (w_blank_end) begin
                     r_state <= ST_SHOW;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               ST_SHOW: begin
                  if (w_dwell_end) begin
                     r_state <= ST_BLANK;
                     r_cnt   <= '0;
                     if (w_last_digit) begin
                        r_idx <= '0;
                        // Swap and a new accept are exclusive: accept needs !pending.
                        if (r_pending) begin
                           r_front_data <= r_back_data;
                           r_front_dp   <= r_back_dp;
                           r_pending    <= 1'b0;
                        end
                     end else begin
                        r_idx <= r_idx + IW'(1);
                     end
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_idx   <= '0;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl (4 digits, dwell 4, blank 2) with a
// write scoreboard feeding the expected displayed frame.
module tb_led_scan_ctrl;

   localparam int N  = 4;
   localparam int DW = 4;
   localparam int BL = 2;
   localparam int FRAME = N * (BL + DW);

   localparam logic [6:0] SEG_TAB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic          clk;
   logic          rst;
   logic          ena;
   logic          wr_vld;
   logic          wr_rdy;
   logic [4*N-1:0] wr_data;
   logic [N-1:0]  wr_dp;
   logic [N-1:0]  dig_sel;
   logic [7:0]    seg;
   logic          frame_done;
   logic [1:0]    dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [19:0]   exp_q[$];
   logic [15:0]   front_data;
   logic [3:0]    front_dp;
   logic          pend;

   led_scan_ctrl #(.N_DIGITS(N), .DWELL(DW), .BLANK_CYC(BL)) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .wr_vld     (wr_vld),
      .wr_rdy     (wr_rdy),
      .wr_data    (wr_data),
      .wr_dp      (wr_dp),
      .dig_sel    (dig_sel),
      .seg        (seg),
      .frame_done (frame_done),
      .dbg_state  (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs ncyc cycles of a frame starting just after the edge entering BLANK
   // of digit 0; up to two writes are offered at frame cycles wa_c / wb_c.
   task automatic check_frame(input string name, input int ncyc,
                              input int wa_c, input logic [15:0] wa_d, input logic [3:0] wa_p,
                              input int wb_c, input logic [15:0] wb_d, input logic [3:0] wb_p);
      int          d;
      int          p;
      logic        acc;
      logic        swap;
      logic [19:0] item;
      logic [3:0]  nib;
      logic [7:0]  exp_seg;
      logic [3:0]  exp_sel;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         d = c / (BL + DW);
         p = c % (BL + DW);
         nib = front_data[d*4 +: 4];
         exp_sel = (p < BL) ? 4'd0 : (4'd1 << d);
         exp_seg = (p < BL) ? 8'h00 : {front_dp[d], SEG_TAB[nib]};
         chk($sformatf("%s c%0d dig_sel", name, c), 32'(dig_sel), 32'(exp_sel));
         chk($sformatf("%s c%0d seg", name, c), 32'(seg), 32'(exp_seg));
         chk($sformatf("%s c%0d frame_done", name, c), 32'(frame_done),
             32'((d == N-1) && (p == BL+DW-1)));
         chk($sformatf("%s c%0d wr_rdy", name, c), 32'(wr_rdy), 32'(!pend));
         chk($sformatf("%s c%0d state", name, c), 32'(dbg_state), (p < BL) ? 32'd1 : 32'd2);
         acc = 1'b0;
         wr_vld = 1'b0;
         if (c == wa_c || c == wb_c) begin
            wr_vld  = 1'b1;
            wr_data = (c == wa_c) ? wa_d : wb_d;
            wr_dp   = (c == wa_c) ? wa_p : wb_p;
            acc     = !pend;
         end
         @(posedge clk);
         swap = (c == FRAME-1) && pend;
         if (swap) begin
            if (exp_q.size() == 0) begin
               chk($sformatf("%s scoreboard empty at swap", name), 32'd1, 32'd0);
            end else begin
               item = exp_q.pop_front();
               front_dp   = item[19:16];
               front_data = item[15:0];
            end
            pend = 1'b0;
         end
         if (acc) begin
            exp_q.push_back({wr_dp, wr_data});
            pend = 1'b1;
         end
      end
      #1 wr_vld = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ena = 1'b0;
      wr_vld = 1'b0;
      wr_data = '0;
      wr_dp = '0;
      front_data = '0;
      front_dp = '0;
      pend = 1'b0;

      repeat (2) @(negedge clk);
      chk("reset dig_sel", 32'(dig_sel), 32'd0);
      chk("reset seg", 32'(seg), 32'd0);
      chk("reset wr_rdy", 32'(wr_rdy), 32'd1);
      chk("reset frame_done", 32'(frame_done), 32'd0);
      chk("reset state", 32'(dbg_state), 32'd0);

      // Run into SHOW with a write pending, then reset between edges.
      rst = 1'b0;
      ena = 1'b1;
      wr_vld = 1'b1;
      wr_data = 16'h8888;
      wr_dp = 4'hF;
      @(posedge clk);
      #1 wr_vld = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("pre-reset dig_sel", 32'(dig_sel), 32'd1);
      chk("pre-reset wr_rdy", 32'(wr_rdy), 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("async reset dig_sel", 32'(dig_sel), 32'd0);
      chk("async reset seg", 32'(seg), 32'd0);
      chk("async reset wr_rdy", 32'(wr_rdy), 32'd1);
      chk("async reset frame_done", 32'(frame_done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);

      check_frame("f1", FRAME, 3, 16'h1234, 4'b0001, 10, 16'hFFFF, 4'b0000);
      check_frame("f2", FRAME, 5, 16'hFFFF, 4'b0000, -1, 16'h0, 4'h0);
      check_frame("f3", FRAME, FRAME-1, 16'h5A6C, 4'b0100, -1, 16'h0, 4'h0);
      check_frame("f4", FRAME, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
      check_frame("f5", 15, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      // Drop ena for one cycle while digit 2 is showing.
      @(negedge clk);
      ena = 1'b0;
      @(negedge clk);
      chk("ena drop dig_sel", 32'(dig_sel), 32'd0);
      chk("ena drop seg", 32'(seg), 32'd0);
      chk("ena drop frame_done", 32'(frame_done), 32'd0);
      chk("ena drop state", 32'(dbg_state), 32'd0);
      chk("ena drop wr_rdy", 32'(wr_rdy), 32'd1);
      ena = 1'b1;
      @(posedge clk);
      check_frame("f6", FRAME, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit 7-segment display built from the shared led_drv-style segment path. Owns one shared hex-to-segment decoder and sequences it across N digits: one-hot digit select, anti-ghosting blank interval, and a double-buffered write port. New values only take effect on frame boundaries, so a digit is never torn mid-frame. Sits between the host/register logic and the board segment/anode pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (2..8)
DWELL, 1000, clock cycles each digit is driven (>=1)
BLANK_CYC, 16, clock cycles all outputs are off before each digit (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
ena  in  1  scan enable; low forces IDLE
wr_vld  in  1  host write request
wr_rdy  out  1  back buffer free; write accepted when wr_vld&&wr_rdy at clk edge
wr_data  in  4*N_DIGITS  hex nibbles; [3:0] = digit 0
wr_dp  in  N_DIGITS  decimal point per digit; bit i = digit i
dig_sel  out  N_DIGITS  one-hot digit enable, active-high
seg  out  8  {dp,g,f,e,d,c,b,a}, active-high
frame_done  out  1  one-cycle pulse at end of last digit's SHOW

Behaviour:
- Registers: front buffer (data+dp, displayed), back buffer, pending flag, state, digit index idx, cycle counter cnt ($clog2 of max(DWELL,BLANK_CYC)).
- Reset (async, rst=1): state=IDLE, idx=0, cnt=0, front=0, back=0, pending=0. Outputs immediately: dig_sel=0, seg=0, frame_done=0, wr_rdy=1.
- Outputs are Moore decodes of registered state/idx/front; no combinational path from inputs to dig_sel/seg.
- wr_rdy = !pending. Accepted write: back<=wr_data/wr_dp, pending<=1. Writes with wr_rdy=0 are ignored (no overwrite).
- FSM:
  IDLE: dig_sel=0, seg=0. ena=1 sampled -> BLANK, idx=0, cnt=0.
  BLANK: dig_sel=0, seg=0. Stays BLANK_CYC cycles (cnt 0..BLANK_CYC-1), then -> SHOW, cnt=0.
  SHOW: dig_sel=1<<idx, seg={front_dp[idx], dec(front_nib[idx])}. Stays DWELL cycles. On last cycle: idx<N-1 -> idx+1, BLANK. idx==N-1 -> idx=0, BLANK, frame_done=1 for this final SHOW cycle; at that edge, if pending: front<=back, pending<=0.
- ena=0 sampled in any state -> IDLE next cycle; idx, cnt cleared; front/back/pending retained; no frame_done, no swap.
- Timing: ena sampled high at edge k -> first SHOW (digit 0) visible from edge k+BLANK_CYC. Frame period = N_DIGITS*(BLANK_CYC+DWELL).
- Simultaneous write accept and frame boundary: pending was 0 (wr_rdy=1), so no swap that edge; new data sets pending, swaps at next boundary.
- dig_sel is never nonzero in two consecutive different digits without at least BLANK_CYC zero cycles between.
- Decoder (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.

Decomposition:
- Package led_pkg: state enum (IDLE, BLANK, SHOW), 16-entry segment constant table, seg bit-position constants.
- Sub-module hex7seg_dec: pure combinational nibble -> 7 segments, one instance, shared by all digits.

Test Plan (N_DIGITS=4, DWELL=4, BLANK_CYC=2):
1. Assert rst mid-simulation without clk edge -> dig_sel=0, seg=00, wr_rdy=1, frame_done=0 immediately; after release with ena=1, digit 0 shows seg=3F after 2 cycles.
2. Write wr_data=16'h1234, wr_dp=4'b0001 during frame 1 -> frame 1 digits all seg=3F; wr_rdy=0 until frame_done; frame 2: dig0 seg=E6, dig1 4F, dig2 5B, dig3 06.
3. Second write 16'hFFFF while pending -> ignored; after swap wr_rdy=1, write accepted, appears one frame later (seg=71).
4. Sequence check: dig_sel pattern 0,0,1x4,0,0,2x4,0,0,4x4,0,0,8x4 repeating; frame_done high exactly in the 4th cycle of dig_sel=8; period 24 cycles.
5. Drop ena during SHOW of digit 2 for one cycle -> next cycle dig_sel=0, seg=0, no frame_done; re-enable -> BLANK 2 cycles then digit 0 (not 2).
6. Write accepted on the same edge as frame_done -> no swap that edge, pending=1, new value displayed from the following frame.
